// File: rtl/mul4_vec_pkg.sv
// Package for the bit-sliced 2x2 multiplier unslicer.
// Contents:
//   LANES_DEF     - default lane count of one vector beat
//   mul4_planes_t - the eight bit-planes of one vector beat (bit i = lane i)
//   unslice_state_t - unslicer FSM state encoding
//   mul2x2()      - golden unsigned 2x2 -> 4-bit product
package mul4_vec_pkg;

  localparam int LANES_DEF = 16;

  typedef struct packed {
    logic [LANES_DEF-1:0] a1;
    logic [LANES_DEF-1:0] a0;
    logic [LANES_DEF-1:0] b1;
    logic [LANES_DEF-1:0] b0;
    logic [LANES_DEF-1:0] y3;
    logic [LANES_DEF-1:0] y2;
    logic [LANES_DEF-1:0] y1;
    logic [LANES_DEF-1:0] y0;
  } mul4_planes_t;

  typedef enum logic {
    EMPTY  = 1'b0,
    SERIAL = 1'b1
  } unslice_state_t;

  // Largest result is 3*3 = 9, so 4 bits never overflow.
  function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mul4_lane_select.sv
// Combinational lane picker: gathers one lane's bits out of the eight planes.
// Ports:
//   planes - held vector beat
//   ptr    - lane index to extract
//   a, b   - lane operands {a1,a0}, {b1,b0}
//   y      - lane product {y3,y2,y1,y0}
module mul4_lane_select
  import mul4_vec_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  localparam int PTR_W = $clog2(LANES)
) (
  input  mul4_planes_t     planes,
  input  logic [PTR_W-1:0] ptr,
  output logic [1:0]       a,
  output logic [1:0]       b,
  output logic [3:0]       y
);

  assign a = {planes.a1[ptr], planes.a0[ptr]};
  assign b = {planes.b1[ptr], planes.b0[ptr]};
  assign y = {planes.y3[ptr], planes.y2[ptr], planes.y1[ptr], planes.y0[ptr]};

endmodule

// File: rtl/mul4_vector_unslicer.sv
// Receive end of the bit-sliced 2x2 multiplier datapath. Takes one vector
// beat of operand/product planes and replays it one lane per cycle, flagging
// lanes whose product disagrees with the golden multiply and keeping a
// saturating error count.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender keeps valid and data stable until that edge, and
// ready may depend on the receiver's state but never on the sender's valid.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - vector beat handshake
//   a1,a0,b1,b0         - operand bit-planes
//   y3,y2,y1,y0         - product bit-planes from the multiplier under test
//   out_valid/out_ready - scalar lane handshake
//   out_lane            - lane index of the current result
//   out_a, out_b, out_y - lane operands and product
//   out_err             - out_y differs from the golden product
//   out_last            - current lane is LANES-1
//   err_count           - saturating count of accepted lanes with out_err
//   clear_cnt           - synchronous clear of err_count, wins over increment
// LANES must equal LANES_DEF, the width of the package plane struct.
module mul4_vector_unslicer
  import mul4_vec_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = 16,
  localparam int PTR_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] a0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W-1:0] out_lane,
  output logic [1:0]       out_a,
  output logic [1:0]       out_b,
  output logic [3:0]       out_y,
  output logic             out_err,
  output logic             out_last,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_cnt
);

  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  unslice_state_t   state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  mul4_planes_t     planes_in, hold;
  logic             load;
  logic             last_lane;
  logic             out_hs;

  assign planes_in = '{a1: a1, a0: a0, b1: b1, b0: b0,
                       y3: y3, y2: y2, y1: y1, y0: y0};
  assign last_lane = (ptr == LAST_LANE);
  assign out_hs    = out_valid & out_ready;

  // Next-state / handshake decode. in_ready looks only at state, ptr,
  // out_ready and rst, so no input-valid to input-ready loop exists.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          load    = 1'b1;
          ptr_n   = '0;
          state_n = SERIAL;
        end
      end
      SERIAL: begin
        out_valid = 1'b1;
        // The last lane leaving frees the buffer in the same cycle, which
        // lets consecutive beats stream without a bubble.
        in_ready  = ~rst & last_lane & out_ready;
        if (out_ready) begin
          if (last_lane) begin
            ptr_n = '0;
            if (in_valid && !rst) begin
              load = 1'b1;
            end else begin
              state_n = EMPTY;
            end
          end else begin
            ptr_n = ptr + PTR_W'(1);
          end
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      if (load) begin
        hold <= planes_in;
      end
    end
  end

  mul4_lane_select #(.LANES(LANES)) u_lane_select (
    .planes (hold),
    .ptr    (ptr),
    .a      (out_a),
    .b      (out_b),
    .y      (out_y)
  );

  assign out_lane = ptr;
  assign out_last = last_lane;
  assign out_err  = (out_y != mul2x2(out_a, out_b));

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      err_count <= '0;
    end else if (out_hs && out_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul4_vector_unslicer.sv
module tb_mul4_vector_unslicer;
  import mul4_vec_pkg::*;

  localparam int LANES = 16;
  localparam int CNT_W = 16;
  localparam int EXP_W = 13; // {lane[3:0], a[1:0], b[1:0], y[3:0], err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             in_valid = 1'b0;
  logic             in_ready;
  mul4_planes_t     cur = '0;
  logic [LANES-1:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_lane;
  logic [1:0]       out_a, out_b;
  logic [3:0]       out_y;
  logic             out_err, out_last;
  logic [CNT_W-1:0] err_count;
  logic             clear_cnt = 1'b0;

  assign a1 = cur.a1; assign a0 = cur.a0; assign b1 = cur.b1; assign b0 = cur.b0;
  assign y3 = cur.y3; assign y2 = cur.y2; assign y1 = cur.y1; assign y0 = cur.y0;

  mul4_vector_unslicer #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_a(out_a), .out_b(out_b), .out_y(out_y), .out_err(out_err),
    .out_last(out_last), .err_count(err_count), .clear_cnt(clear_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d @%0t", name, got, want, $time);
    end
  endtask

  // Reference lane result built straight from the planes.
  function automatic logic [EXP_W-1:0] lane_exp(input mul4_planes_t p, input int i);
    logic [1:0] a, b;
    logic [3:0] y, prod;
    a    = {p.a1[i], p.a0[i]};
    b    = {p.b1[i], p.b0[i]};
    y    = {p.y3[i], p.y2[i], p.y1[i], p.y0[i]};
    prod = 4'(a) * 4'(b);
    return {4'(i), a, b, y, (y != prod)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input mul4_planes_t p);
    int n = 0;
    cur      = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < LANES; i++) exp_q.push_back(lane_exp(p, i));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic             prev_stall = 1'b0;
  logic [EXP_W-1:0] held = '0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] got, want;
    got = {out_lane, out_a, out_b, out_y, out_err};
    if (rst) begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("err_count", int'(err_count), int'(exp_cnt));
      if (prev_stall) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_data_held", int'(got), int'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          want = exp_q.pop_front();
          check("lane_result", int'(got), int'(want));
          check("out_last", int'(out_last), int'(want[EXP_W-1 -: 4] == 4'(LANES-1)));
          if (want[0] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
      end
      if (clear_cnt) exp_cnt = '0;
      prev_stall = out_valid && !out_ready;
      held       = got;
    end
  end

  // ---------------- stimulus ----------------
  mul4_planes_t p;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err_count", int'(err_count), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // all planes zero: 16 lanes of 0*0=0, no errors
    send_beat('0);
    drain();
    check("zero_beat_err_count", int'(err_count), 0);

    // every lane 3*3 with y=9 (1001)
    p = '0;
    p.a1 = 16'hFFFF; p.a0 = 16'hFFFF; p.b1 = 16'hFFFF; p.b0 = 16'hFFFF;
    p.y3 = 16'hFFFF; p.y0 = 16'hFFFF;
    send_beat(p);
    drain();
    check("three_sq_err_count", int'(err_count), 0);

    // lane 0 computes 1*1 but reports 0
    p = '0;
    p.a0 = 16'h0001; p.b0 = 16'h0001;
    send_beat(p);
    drain();
    check("lane0_err_count", int'(err_count), 1);

    // two beats back to back: 32 valid cycles, in_ready only on lane 15
    p = '0;
    p.a1 = 16'h00FF; p.a0 = 16'h0F0F; p.b1 = 16'h3333; p.b0 = 16'h5555;
    p.y2 = 16'h1234;
    fork
      begin
        send_beat(p);
        send_beat(~p);
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        while (!out_valid && n < 50) begin
          n++;
          @(posedge clk); #1;
        end
        for (int i = 0; i < 2 * LANES; i++) begin
          check("b2b_out_valid", int'(out_valid), 1);
          check("b2b_in_ready", int'(in_ready), int'(out_lane == 4'(LANES-1)));
          @(posedge clk); #1;
        end
        check("b2b_idle_after", int'(out_valid), 0);
      end
    join
    drain();

    // stall on lane 3: ready 1 on entry, 0, 0, then 1
    p = '0;
    p.a1 = 16'hAAAA; p.a0 = 16'hCCCC; p.b1 = 16'hF0F0; p.b0 = 16'hFF00;
    p.y3 = 16'h00FF; p.y1 = 16'h0F0F;
    send_beat(p);
    begin
      int n = 0;
      while (!(out_valid && out_lane == 4'd3) && n < 50) begin
        n++;
        @(posedge clk); #1;
      end
      check("reach_lane3", int'(out_lane), 3);
      out_ready = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        check("stall_lane_held", int'(out_lane), 3);
      end
      out_ready = 1'b1;
    end
    drain();

    // reset in the middle of a beat with errors on every lane (1*1 reported 0)
    p = '0;
    p.a0 = 16'hFFFF; p.b0 = 16'hFFFF;
    send_beat(p);
    begin
      int n = 0;
      while (!(out_valid && out_lane == 4'd7) && n < 50) begin
        n++;
        @(posedge clk); #1;
      end
      check("reach_lane7", int'(out_lane), 7);
      rst = 1'b1;
      #1;
      check("rst_hold_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      exp_q.delete();
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      check("midrst_err_count", int'(err_count), 0);
      rst = 1'b0;
    end
    p = '0;
    p.a1 = 16'h8001; p.b1 = 16'h8001; p.y2 = 16'h8001;
    send_beat(p);
    #1;
    check("post_rst_lane0", int'(out_lane), 0);
    check("post_rst_valid", int'(out_valid), 1);
    drain();

    // saturation: 4097 beats * 16 erroring lanes exceeds 16'hFFFF
    p = '0;
    p.a0 = 16'hFFFF; p.b0 = 16'hFFFF;
    for (int k = 0; k < 4097; k++) send_beat(p);
    drain();
    check("sat_err_count", int'(err_count), 32'h0000FFFF);
    clear_cnt = 1'b1;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
    check("cleared_err_count", int'(err_count), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
